i2c_slave_frontend: RTL and testbench

- Serial front end of the I2C flash memory model; sits directly upstream of the controller, address register and data buffer.
- Oversamples SCL/SDA on the system clock and detects START/STOP. Decodes the device-address byte and a 16-bit memory address (high byte then low byte).
- Converts serial write/read transfers into single-cycle parallel memory strobes.
- Drives SDA open-drain (ACK and read data) and auto-increments the memory address per byte.

---
 rtl/i2c_slave_frontend.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_slave_frontend.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_frontend.sv
// rtl/i2c_slave_frontend.sv - I2C slave serial front end producing parallel memory strobes
`timescale 1ns/1ps
module i2c_slave_frontend #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    input  logic        sdaIn,
    output logic        sdaOe,
    output logic [15:0] memAddr,
    output logic [7:0]  memWrData,
    output logic        memWrEn,
    output logic        memRdEn,
    input  logic [7:0]  memRdData,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
        WR_DATA, ACK_WR, RD_LOAD, RD_DATA, RD_MACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [15:0]            mem_addr_q, mem_addr_d;
    logic [7:0]             mem_wr_data_q, mem_wr_data_d;
    logic                   mem_wr_en_q, mem_wr_en_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic                   busy_q, busy_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       last_bit;
    logic [7:0] rx_byte;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign last_bit  = (bit_cnt_q == 4'd7);
    assign rx_byte   = {shift_q[6:0], sda_s};

    always_comb begin
        scl_sync_d    = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d    = {sda_sync_q[SYNC_STAGES-2:0], sdaIn};
        scl_prev_d    = scl_s;
        sda_prev_d    = sda_s;
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        sda_oe_d      = sda_oe_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_wr_en_d   = 1'b0;
        mem_rd_en_d   = 1'b0;
        busy_d        = busy_q;

        // Post-increment the address on the clk after a write strobe.
        if (mem_wr_en_q) begin
            mem_addr_d = mem_addr_q + 16'd1;
        end

        case (state_q)
            DEVADDR: begin
                if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        bit_cnt_d = 4'd0;
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            busy_d  = 1'b1;
                            state_d = ACK_DEV;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
            end
            ADDR_HI, ADDR_LO, WR_DATA: begin
                if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR_HI) begin
                            mem_addr_d[15:8] = rx_byte;
                            state_d          = ACK_HI;
                        end else if (state_q == ADDR_LO) begin
                            mem_addr_d[7:0] = rx_byte;
                            state_d         = ACK_LO;
                        end else begin
                            mem_wr_data_d = rx_byte;
                            mem_wr_en_d   = 1'b1;
                            state_d       = ACK_WR;
                        end
                    end
                end
            end
            ACK_DEV, ACK_HI, ACK_LO, ACK_WR: begin
                // First fall pulls SDA low, second fall ends the ACK slot.
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (state_q == ACK_DEV && shift_q[0]) begin
                        // Keep SDA held until the first read bit replaces it.
                        state_d     = RD_LOAD;
                        mem_rd_en_d = 1'b1;
                        bit_cnt_d   = 4'd0;
                    end else begin
                        sda_oe_d = 1'b0;
                        if (state_q == ACK_DEV)     state_d = ADDR_HI;
                        else if (state_q == ACK_HI) state_d = ADDR_LO;
                        else                        state_d = WR_DATA;
                    end
                end
            end
            RD_LOAD: begin
                case (bit_cnt_q)
                    4'd0: bit_cnt_d = 4'd1;
                    4'd1: begin
                        shift_d   = memRdData;
                        bit_cnt_d = 4'd2;
                    end
                    default: begin
                        if (!scl_s) begin
                            sda_oe_d  = ~shift_q[7];
                            bit_cnt_d = 4'd0;
                            state_d   = RD_DATA;
                        end
                    end
                endcase
            end
            RD_DATA: begin
                if (scl_fall) begin
                    if (last_bit) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = RD_MACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oe_d  = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            RD_MACK: begin
                if (scl_rise) begin
                    mem_addr_d = mem_addr_q + 16'd1;
                    if (!sda_s) begin
                        state_d     = RD_LOAD;
                        mem_rd_en_d = 1'b1;
                        bit_cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
            end
            IDLE, WAIT_STOP: ;
            default: state_d = IDLE;
        endcase

        if (start_det) begin
            state_d     = DEVADDR;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            mem_wr_en_d = 1'b0;
            mem_rd_en_d = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            mem_wr_en_d = 1'b0;
            mem_rd_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q    <= '1;
            sda_sync_q    <= '1;
            scl_prev_q    <= 1'b1;
            sda_prev_q    <= 1'b1;
            state_q       <= IDLE;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 8'd0;
            sda_oe_q      <= 1'b0;
            mem_addr_q    <= 16'd0;
            mem_wr_data_q <= 8'd0;
            mem_wr_en_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            scl_sync_q    <= scl_sync_d;
            sda_sync_q    <= sda_sync_d;
            scl_prev_q    <= scl_prev_d;
            sda_prev_q    <= sda_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            sda_oe_q      <= sda_oe_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_rd_en_q   <= mem_rd_en_d;
            busy_q        <= busy_d;
        end
    end

    assign sdaOe     = sda_oe_q;
    assign memAddr   = mem_addr_q;
    assign memWrData = mem_wr_data_q;
    assign memWrEn   = mem_wr_en_q;
    assign memRdEn   = mem_rd_en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_frontend.sv
// tb/tb_i2c_slave_frontend.sv - directed bench for i2c_slave_frontend
`timescale 1ns/1ps
module tb_i2c_slave_frontend;

    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_line;
    logic        sdaOe;
    logic [15:0] memAddr;
    logic [7:0]  memWrData;
    logic        memWrEn;
    logic        memRdEn;
    logic [7:0]  memRdData = 8'h00;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;
    int both_cnt = 0;
    logic [15:0] wr_addr_log [0:31];
    logic [7:0]  wr_data_log [0:31];
    logic [15:0] rd_addr_log [0:31];

    assign sda_line = m_sda & ~sdaOe;

    i2c_slave_frontend #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (m_scl),
        .sdaIn     (sda_line),
        .sdaOe     (sdaOe),
        .memAddr   (memAddr),
        .memWrData (memWrData),
        .memWrEn   (memWrEn),
        .memRdEn   (memRdEn),
        .memRdData (memRdData),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory side: log strobes, answer reads on the clk after memRdEn.
    always @(negedge clk) begin
        if (memWrEn) begin
            wr_addr_log[wr_cnt % 32] = memAddr;
            wr_data_log[wr_cnt % 32] = memWrData;
            wr_cnt++;
        end
        if (memRdEn) begin
            rd_addr_log[rd_cnt % 32] = memAddr;
            rd_cnt++;
            memRdData = (memAddr == 16'h0010) ? 8'hC3 :
                        (memAddr == 16'h0011) ? 8'h3C : 8'hEE;
        end
        if (sdaOe) oe_cnt++;
        if (memWrEn && memRdEn) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_sda = 1'b0; wait_clks(H);
        m_scl = 1'b0; wait_clks(2);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_sda = 1'b1; wait_clks(H);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; wait_clks(H);
            m_scl = 1'b1; wait_clks(H);
            m_scl = 1'b0; wait_clks(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; wait_clks(H);
        m_scl = 1'b1; wait_clks(H/2);
        ack = (sda_line === 1'b0);
        wait_clks(H/2);
        m_scl = 1'b0; wait_clks(2);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clks(H);
            m_scl = 1'b1; wait_clks(H/2);
            b[i] = sda_line;
            wait_clks(H/2);
            m_scl = 1'b0; wait_clks(2);
        end
        m_sda = mack; wait_clks(H);
        m_scl = 1'b1; wait_clks(H);
        m_scl = 1'b0; wait_clks(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(3);
        checks++; if (sdaOe !== 1'b0) begin failures++; $display("FAIL reset_sdaOe got=%b exp=0", sdaOe); end
        checks++; if (memAddr !== 16'h0000) begin failures++; $display("FAIL reset_memAddr got=%h exp=0000", memAddr); end
        checks++; if (memWrData !== 8'h00) begin failures++; $display("FAIL reset_memWrData got=%h exp=00", memWrData); end
        checks++; if (memWrEn !== 1'b0) begin failures++; $display("FAIL reset_memWrEn got=%b exp=0", memWrEn); end
        checks++; if (memRdEn !== 1'b0) begin failures++; $display("FAIL reset_memRdEn got=%b exp=0", memRdEn); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        wait_clks(5);
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h12, a1);
        send_byte(8'h34, a2);
        send_byte(8'h5A, a3);
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL wr_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_in_frame got=%b exp=1", busy); end
        i2c_stop();
        checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL wr_strobe_count got=%0d exp=1", wr_cnt - w0); end
        checks++; if (wr_addr_log[w0 % 32] !== 16'h1234) begin failures++; $display("FAIL wr_addr got=%h exp=1234", wr_addr_log[w0 % 32]); end
        checks++; if (wr_data_log[w0 % 32] !== 8'h5A) begin failures++; $display("FAIL wr_data got=%h exp=5a", wr_data_log[w0 % 32]); end
        checks++; if (memAddr !== 16'h1235) begin failures++; $display("FAIL wr_addr_after got=%h exp=1235", memAddr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_burst_wrap();
        logic a0, a1, a2, a3, a4;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'hFF, a2);
        send_byte(8'h11, a3);
        send_byte(8'h22, a4);
        i2c_stop();
        checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin failures++; $display("FAIL wrap_acks got=%b exp=11111", {a0, a1, a2, a3, a4}); end
        checks++; if (wr_cnt - w0 !== 2) begin failures++; $display("FAIL wrap_strobe_count got=%0d exp=2", wr_cnt - w0); end
        checks++; if (wr_addr_log[w0 % 32] !== 16'hFFFF) begin failures++; $display("FAIL wrap_addr0 got=%h exp=ffff", wr_addr_log[w0 % 32]); end
        checks++; if (wr_data_log[w0 % 32] !== 8'h11) begin failures++; $display("FAIL wrap_data0 got=%h exp=11", wr_data_log[w0 % 32]); end
        checks++; if (wr_addr_log[(w0 + 1) % 32] !== 16'h0000) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0000", wr_addr_log[(w0 + 1) % 32]); end
        checks++; if (wr_data_log[(w0 + 1) % 32] !== 8'h22) begin failures++; $display("FAIL wrap_data1 got=%h exp=22", wr_data_log[(w0 + 1) % 32]); end
        checks++; if (memAddr !== 16'h0001) begin failures++; $display("FAIL wrap_addr_after got=%h exp=0001", memAddr); end
    endtask

    task automatic test_random_read();
        logic a0, a1, a2, a3;
        logic [7:0] b0, b1;
        int r0, w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h00, a1);
        send_byte(8'h10, a2);
        i2c_start();
        send_byte(8'hA1, a3);
        recv_byte(1'b0, b0);
        recv_byte(1'b1, b1);
        checks++; if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL rd_acks got=%b exp=1111", {a0, a1, a2, a3}); end
        checks++; if (b0 !== 8'hC3) begin failures++; $display("FAIL rd_byte0 got=%h exp=c3", b0); end
        checks++; if (b1 !== 8'h3C) begin failures++; $display("FAIL rd_byte1 got=%h exp=3c", b1); end
        checks++; if (rd_cnt - r0 !== 2) begin failures++; $display("FAIL rd_strobe_count got=%0d exp=2", rd_cnt - r0); end
        checks++; if (rd_addr_log[r0 % 32] !== 16'h0010) begin failures++; $display("FAIL rd_addr0 got=%h exp=0010", rd_addr_log[r0 % 32]); end
        checks++; if (rd_addr_log[(r0 + 1) % 32] !== 16'h0011) begin failures++; $display("FAIL rd_addr1 got=%h exp=0011", rd_addr_log[(r0 + 1) % 32]); end
        checks++; if (memAddr !== 16'h0012) begin failures++; $display("FAIL rd_addr_after got=%h exp=0012", memAddr); end
        checks++; if (sdaOe !== 1'b0) begin failures++; $display("FAIL rd_sda_released got=%b exp=0", sdaOe); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_after_stop got=%b exp=0", busy); end
        checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL rd_no_writes got=%0d exp=0", wr_cnt - w0); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        int w0, r0, o0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        o0 = oe_cnt;
        i2c_start();
        send_byte(8'hA2, a0);
        send_byte(8'h55, a1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mis_busy got=%b exp=0", busy); end
        i2c_stop();
        checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL mis_acks got=%b exp=00", {a0, a1}); end
        checks++; if (oe_cnt - o0 !== 0) begin failures++; $display("FAIL mis_sdaOe_cycles got=%0d exp=0", oe_cnt - o0); end
        checks++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin failures++; $display("FAIL mis_strobes got=%0d exp=0", (wr_cnt - w0) + (rd_cnt - r0)); end
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1, a2;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h00, a1);
        send_byte(8'h20, a2);
        send_bits(8'hF0, 4);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL smb_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL smb_no_write got=%0d exp=0", wr_cnt - w0); end
        checks++; if (sdaOe !== 1'b0) begin failures++; $display("FAIL smb_sdaOe got=%b exp=0", sdaOe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL smb_busy got=%b exp=0", busy); end
        checks++; if (memAddr !== 16'h0020) begin failures++; $display("FAIL smb_memAddr got=%h exp=0020", memAddr); end
    endtask

    task automatic test_async_reset();
        logic a0, a1, a2, a3, a4, a5, a6;
        int w0;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h00, a1);
        send_byte(8'h05, a2);
        send_bits(8'h77, 8);
        wait_clks(H);
        checks++; if (sdaOe !== 1'b1) begin failures++; $display("FAIL ar_ack_before_reset got=%b exp=1", sdaOe); end
        #1 reset = 1'b1;
        #1;
        checks++; if (sdaOe !== 1'b0) begin failures++; $display("FAIL ar_sdaOe got=%b exp=0", sdaOe); end
        checks++; if (memAddr !== 16'h0000) begin failures++; $display("FAIL ar_memAddr got=%h exp=0000", memAddr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
        m_sda = 1'b0; wait_clks(4);
        m_scl = 1'b1; wait_clks(4);
        m_sda = 1'b1; wait_clks(4);
        reset = 1'b0;
        wait_clks(5);
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'hA0, a3);
        send_byte(8'h00, a4);
        send_byte(8'h07, a5);
        send_byte(8'h99, a6);
        i2c_stop();
        checks++; if ({a0, a1, a2, a3, a4, a5, a6} !== 7'h7F) begin failures++; $display("FAIL ar_acks got=%b exp=1111111", {a0, a1, a2, a3, a4, a5, a6}); end
        checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL ar_strobe_count got=%0d exp=1", wr_cnt - w0); end
        checks++; if (wr_addr_log[w0 % 32] !== 16'h0007) begin failures++; $display("FAIL ar_wr_addr got=%h exp=0007", wr_addr_log[w0 % 32]); end
        checks++; if (wr_data_log[w0 % 32] !== 8'h99) begin failures++; $display("FAIL ar_wr_data got=%h exp=99", wr_data_log[w0 % 32]); end
        checks++; if (memAddr !== 16'h0008) begin failures++; $display("FAIL ar_addr_after got=%h exp=0008", memAddr); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_burst_wrap();
        test_random_read();
        test_addr_mismatch();
        test_stop_mid_byte();
        test_async_reset();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
